// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and result selection for the RV32M mul/div unit.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier in muldiv_stall_unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned XLEN2 = 2 * XLEN;
    localparam int unsigned CNT_W = 6;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    // MUL and all divides return the low word; MULH variants return the high word.
    function automatic logic [XLEN-1:0] pick_result(input logic [2:0] f3, input logic [XLEN2-1:0] v);
        return ((f3 == F3_MUL) || f3[2]) ? v[XLEN-1:0] : v[XLEN2-1:XLEN];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling per funct3: mode 0 returns {|rs2|, |rs1|}, mode 1 returns the
// sign-corrected 2*XLEN raw result (product, quotient or remainder in the low word).
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic             mode_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  op_a_i,
    input  logic [XLEN-1:0]  op_b_i,
    input  logic [XLEN2-1:0] res_i,
    output logic [XLEN2-1:0] val_o
);

    logic            a_signed;
    logic            b_signed;
    logic            neg_a;
    logic            neg_b;
    logic            neg_res;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    always_comb begin
        a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                   (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        neg_a    = a_signed & op_a_i[XLEN-1];
        neg_b    = b_signed & op_b_i[XLEN-1];
        mag_a    = neg_a ? (XLEN'(0) - op_a_i) : op_a_i;
        mag_b    = neg_b ? (XLEN'(0) - op_b_i) : op_b_i;

        // Remainder follows the dividend; quotient/product follow the sign product.
        if (!funct3_i[2])
            neg_res = neg_a ^ neg_b;
        else if (funct3_i[1])
            neg_res = neg_a;
        else
            neg_res = (neg_a ^ neg_b) && (op_b_i != '0);

        if (!mode_i)
            val_o = {mag_b, mag_a};
        else
            val_o = neg_res ? (XLEN2'(0) - res_i) : res_i;
    end

endmodule

// File: rtl/muldiv_stall_unit.sv
// Iterative RV32M multiply/divide for EX with pipeline stall request, flush abort and result pulse.
// Build option: MULDIV_FAST_MUL_EN replaces the iterative multiplier with a single-cycle one.
module muldiv_stall_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       rd_q, rd_d, rd_out_q, rd_out_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             div_zero, div_ovf, special;
    logic [XLEN-1:0]  special_res;
    logic [XLEN2-1:0] pre_val;
    logic [XLEN-1:0]  pre_a, pre_b;

    logic [XLEN:0]    mul_sum, div_shift, div_diff;
    logic             div_ok;
    logic [XLEN-1:0]  hi_n, lo_n;
    logic [XLEN2-1:0] step_raw;

    logic [2:0]       post_f3;
    logic [XLEN-1:0]  post_a, post_b;
    logic [XLEN2-1:0] post_raw, post_val;

    muldiv_signfix u_pre (
        .mode_i   (1'b0),
        .funct3_i (funct3),
        .op_a_i   (rs1_val),
        .op_b_i   (rs2_val),
        .res_i    ('0),
        .val_o    (pre_val)
    );

    muldiv_signfix u_post (
        .mode_i   (1'b1),
        .funct3_i (post_f3),
        .op_a_i   (post_a),
        .op_b_i   (post_b),
        .res_i    (post_raw),
        .val_o    (post_val)
    );

    assign pre_a  = pre_val[XLEN-1:0];
    assign pre_b  = pre_val[XLEN2-1:XLEN];
    assign accept = (state_q == IDLE) && start && !flush;

    // Divide cases resolved at accept without iterating.
    always_comb begin
        div_zero    = funct3[2] && (rs2_val == '0);
        div_ovf     = funct3[2] && !funct3[0] && (rs1_val == INT_MIN) && (rs2_val == DIV_ZERO_Q);
        special     = div_zero || div_ovf;
        special_res = div_zero ? (funct3[1] ? rs1_val : DIV_ZERO_Q)
                               : (funct3[1] ? '0 : INT_MIN);
    end

    // One shift-add (MUL) or restoring-subtract (DIV) step on hi/lo/opnd.
    always_comb begin
        mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = !div_diff[XLEN];
        if (state_q == DIV) begin
            hi_n = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], div_ok};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (!f3_q[2])
            step_raw = {hi_n, lo_n};
        else if (f3_q[1])
            step_raw = {{XLEN{1'b0}}, hi_n};
        else
            step_raw = {{XLEN{1'b0}}, lo_n};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN2-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, pre_a} * {{XLEN{1'b0}}, pre_b};
    // In IDLE the post fixer serves the accepting instruction's fast product.
    assign post_f3  = (state_q == IDLE) ? funct3    : f3_q;
    assign post_a   = (state_q == IDLE) ? rs1_val   : a_q;
    assign post_b   = (state_q == IDLE) ? rs2_val   : b_q;
    assign post_raw = (state_q == IDLE) ? fast_prod : step_raw;
`else
    assign post_f3  = f3_q;
    assign post_a   = a_q;
    assign post_b   = b_q;
    assign post_raw = step_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (special)
                        state_d = DIV;
                    else
                        state_d = funct3[2] ? DIV : MUL;
                    if (special) state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    if (!funct3[2]) state_d = DONE;
`endif
                end
            end
            MUL, DIV: if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:     state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        stall_req = rst_n && (accept || (((state_q == MUL) || (state_q == DIV)) && !flush));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    f3_d   = funct3;
                    a_d    = rs1_val;
                    b_d    = rs2_val;
                    rd_d   = rd_in;
                    cnt_d  = CNT_W'(XLEN);
                    hi_d   = '0;
                    lo_d   = funct3[2] ? pre_a : pre_b;
                    opnd_d = funct3[2] ? pre_b : pre_a;
                    if (special) begin
                        result_d = special_res;
                        rd_out_d = rd_in;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (!funct3[2]) begin
                        result_d = pick_result(post_f3, post_val);
                        rd_out_d = rd_in;
                    end
`endif
                end
            end
            MUL, DIV: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = pick_result(post_f3, post_val);
                    rd_out_d = rd_q;
                end
            end
            DONE: rd_out_d = '0;
        endcase

        // A killed operation leaves the visible result and rd untouched.
        if (flush) begin
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            valid_q  <= valid_d;
        end
    end

    assign result_valid = valid_q;
    assign result       = result_q;
    assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_muldiv_stall_unit.sv
// Directed bench for muldiv_stall_unit: multiply/divide results, stall lengths, flush and reset.
`timescale 1ns/1ps
module tb_muldiv_stall_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_req;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_stall_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .funct3       (funct3),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op with start held until the result pulse, then release start.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_stall);
        int stalls;
        int cyc;
        bit got;
        stalls = 0;
        cyc    = 0;
        got    = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
        while (!got && cyc < 200) begin
            @(negedge clk);
            if (result_valid) got = 1'b1;
            else begin
                if (stall_req) stalls++;
                @(posedge clk); #1;
            end
            cyc++;
        end
        check({tag, "_done"},      32'(got),       32'd1);
        check({tag, "_result"},    result,         exp);
        check({tag, "_rd"},        32'(rd_out),    32'(rd));
        check({tag, "_stalls"},    32'(stalls),    32'(exp_stall));
        check({tag, "_donestall"}, 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"},  32'(result_valid), 32'd0);
        check({tag, "_rdidle"}, 32'(rd_out),       32'd0);
        check({tag, "_hold"},   result,            exp);
    endtask

    initial begin
        int nv;
        rst_n = 1'b0; start = 1'b1; flush = 1'b0;
        funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'hFFFF_FFFD; rd_in = 5'd9;

        @(negedge clk);
        check("rst_valid",  32'(result_valid), 32'd0);
        check("rst_result", result,            32'd0);
        check("rst_rd",     32'(rd_out),       32'd0);
        check("rst_stall",  32'(stall_req),    32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        run_op("mul",     3'b000, 32'd7,         32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, MUL_STALL);
        run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, MUL_STALL);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, MUL_STALL);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, MUL_STALL);
        run_op("div_z",   3'b100, 32'd5,         32'd0,         5'd6,  32'hFFFF_FFFF, 1);
        run_op("remu_z",  3'b111, 32'd5,         32'd0,         5'd7,  32'd5,         1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1);
        run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, DIV_STALL);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFF, DIV_STALL);

        // Flush ten cycles into a DIVU.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd13;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush_idle",   32'(stall_req), 32'd0);
        check("flush_rd",     32'(rd_out),    32'd0);
        check("flush_result", result,         32'hFFFF_FFFF);
        nv = 0;
        repeat (40) begin @(negedge clk); if (result_valid) nv++; end
        check("flush_novalid", 32'(nv), 32'd0);
        run_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 5'd13, 32'd14, DIV_STALL);
        run_op("remu",             3'b111, 32'd100, 32'd7, 5'd14, 32'd2,  DIV_STALL);

        // Flush in the same cycle as a would-be accept.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'b101; rs1_val = 32'd50; rs2_val = 32'd3;
        @(negedge clk);
        check("coinc_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("coinc_noaccept", 32'(stall_req),    32'd0);
        check("coinc_novalid",  32'(result_valid), 32'd0);

        // Reset in the middle of a multiply with start held high.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd5; rd_in = 5'd15;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mrst_valid",  32'(result_valid), 32'd0);
        check("mrst_result", result,            32'd0);
        check("mrst_rd",     32'(rd_out),       32'd0);
        check("mrst_stall",  32'(stall_req),    32'd0);
        repeat (2) @(negedge clk);
        check("mrst_hold_stall", 32'(stall_req), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd5, 5'd15, 32'd15, MUL_STALL);
        nv = 0;
        repeat (5) begin @(negedge clk); if (result_valid) nv++; end
        check("single_pulse", 32'(nv), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
